serial_frame_arbiter: RTL and testbench
=======================================

Name: serial_frame_arbiter

Overview:
Shares one serial line, which feeds the preamble-detecting Moore receiver and its payload counter, among NREQ parallel requesters. The block picks a requester round-robin, captures its word, and serializes one frame: preamble 1011, then the requester ID, then the data word, then a guard gap. The receiver sees 1011 and enters its payload state; the guard gap lets it return to idle. Line bits change only on bit_en strobes, the same debounced/divided enable that drives the receiver's clk_en.

Parameters:
NREQ, 4, number of requesters (power of 2, >=2)
DATA_W, 4, payload data bits per request
GAP_BITS, 2, number of idle-low strobes after each frame (>=1)

Ports:
clk  in  1  system clock, all state on posedge
rst_n  in  1  asynchronous, active-low reset
bit_en  in  1  one-clk serial bit strobe
req  in  NREQ  request per requester; held until its ack
req_data  in  NREQ*DATA_W  word i at bits [i*DATA_W +: DATA_W]
ack  out  NREQ  one-clk pulse: word i captured
ser_out  out  1  serial line to receiver SerIn; idle level 0
frame_active  out  1  high while preamble or payload bits are on the line
busy  out  1  high in every state except IDLE
gnt_id  out  clog2(NREQ)  ID of the current or last granted requester

Behaviour:
- Reset (async, rst_n=0): state IDLE, ser_out=0, ack=0, frame_active=0, busy=0, gnt_id=0, RR pointer=0, bit index=0, shift register=0.
- The ID width is ID_W=clog2(NREQ). Payload length is PAY_LEN=ID_W+DATA_W. The payload is the ID MSB-first followed by the data MSB-first.
- States: IDLE, PRE, PAY, GAP.
- IDLE: if any req bit is high, then at the next clk edge (independent of bit_en) the block:
  - grants the winner,
  - loads the shift register with {id, req_data[id]},
  - sets gnt_id=id,
  - registers ack[id]=1 for exactly one cycle,
  - moves to PRE with idx=0 and advances the RR pointer to id+1 mod NREQ.
- Round-robin: search starts at the RR pointer and wraps; the first set req bit wins. With all req low, the block stays in IDLE and ser_out=0.
- PRE: on each bit_en edge, ser_out<=1011[3-idx] and idx++. After the 4th bit, go to PAY with idx=0. frame_active is set at the first PRE bit edge.
- PAY: on each bit_en edge, ser_out<=shift MSB, shift left, idx++. After PAY_LEN bits, go to GAP with idx=0.
- GAP: on each bit_en edge, ser_out<=0 and idx++. frame_active clears at the first GAP edge, so the last payload bit is held one full strobe period. After GAP_BITS edges, go to IDLE; busy clears at the same edge.
- Bit hold: without bit_en, ser_out holds its value. Strobe spacing is arbitrary (>=1 clk), and back-to-back bit_en on every clk is legal.
- bit_en on the grant edge is ignored for line purposes. The first preamble bit appears at the first bit_en edge strictly after the grant edge.
- New request during a frame: it is ignored until IDLE. A requester still holding req after its ack re-competes only after GAP and loses to other pending requesters.
- A req that drops before its grant is never granted. Data changes after ack have no effect.
- Reset mid-frame: the line returns to 0 immediately. No ack is reissued; the requester must re-request.
- A frame occupies 4+PAY_LEN+GAP_BITS strobes, plus 1 clk for the grant.

Decomposition:
- Package serial_frame_pkg holds:
  - the state enum {IDLE, PRE, PAY, GAP},
  - the constant PREAMBLE=4'b1011,
  - the constant LINE_IDLE=1'b0,
  - a function for ID_W.
- Sub-module rr_arbiter(clk, rst_n, req, advance -> gnt_onehot, gnt_id) holds the pointer register and the wrap search. The top holds the FSM, shift register, and bit counter.

Test Plan:
- Single request, NREQ=4, DATA_W=4, bit_en every 3rd clk, req[2]=1, data 4'hA:
  - ack[2] pulses once and gnt_id=2.
  - ser_out over strobes is 1,0,1,1,1,0,1,0,1,0 then 0,0.
  - frame_active covers exactly 10 strobes and busy clears after the 2nd gap strobe.
- All req=4'b1111 held, data i=4'h5+i: ack order is 0,1,2,3,0. Each frame carries the matching ID and data, with no back-to-back grant to the same requester while others are pending.
- Pointer wrap: the pointer is at 3 after granting 2, and req=4'b0011 -> grant 0 then 1.
- bit_en stuck high every clk, req[1]=1, data 4'h3 -> a 12-clk line sequence 1,0,1,1,0,1,0,0,1,1,0,0, with the next grant no earlier than the cycle after GAP ends.
- rst_n pulsed low mid-PAY -> ser_out=0, busy=0 and ack=0 asynchronously. After release, a fresh request restarts from the preamble with the pointer at 0.
- End-to-end: connect ser_out to the receiver (counter terminal count=PAY_LEN) and send 4 random frames. The receiver SerOutValid window must contain exactly the 6 payload bits of each frame, and the receiver must return to idle within the gap.

Source files
------------

// File: rtl/serial_frame_pkg.sv
// Shared types and constants for the serial frame arbiter.
package serial_frame_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        PAY  = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [3:0] PREAMBLE  = 4'b1011;
    localparam logic       LINE_IDLE = 1'b0;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_frame_arbiter_rr.sv
// Round-robin requester selection with a registered search-start pointer.
module rr_arbiter
    import serial_frame_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] gnt_onehot,
    output logic [ID_W-1:0] gnt_id
);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] cand;
    logic            found;

    // NREQ is a power of two, so the candidate index wraps naturally.
    always_comb begin
        found  = 1'b0;
        gnt_id = ptr;
        cand   = ptr;
        for (int k = 0; k < NREQ; k++) begin
            cand = ptr + ID_W'(k);
            if (!found && req[cand]) begin
                found  = 1'b1;
                gnt_id = cand;
            end
        end
        gnt_onehot = found ? (NREQ'(1) << gnt_id) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= gnt_id + ID_W'(1);
        end
    end

endmodule

// File: rtl/serial_frame_arbiter.sv
// Grants one requester, then serializes preamble, ID, data and a guard gap on bit_en strobes.
module serial_frame_arbiter
    import serial_frame_pkg::*;
#(
    parameter  int NREQ     = 4,
    parameter  int DATA_W   = 4,
    parameter  int GAP_BITS = 2,
    localparam int ID_W     = id_width(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   bit_en,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        ack,
    output logic                   ser_out,
    output logic                   frame_active,
    output logic                   busy,
    output logic [ID_W-1:0]        gnt_id
);

    localparam int PAY_LEN = ID_W + DATA_W;
    localparam int MAX_A   = (PAY_LEN > 4) ? PAY_LEN : 4;
    localparam int MAX_CNT = (GAP_BITS > MAX_A) ? GAP_BITS : MAX_A;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    state_t               state, state_d;
    logic [CNT_W-1:0]     idx, idx_d;
    logic [PAY_LEN-1:0]   shift, shift_d;
    logic                 ser_d;
    logic                 fa_d;
    logic [NREQ-1:0]      ack_d;
    logic [ID_W-1:0]      gid_d;

    logic                 advance;
    logic [NREQ-1:0]      win_onehot;
    logic [ID_W-1:0]      win_id;
    logic [DATA_W-1:0]    win_word;
    logic [1:0]           pre_sel;

    rr_arbiter #(
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) u_rr (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .advance    (advance),
        .gnt_onehot (win_onehot),
        .gnt_id     (win_id)
    );

    assign win_word = req_data[win_id*DATA_W +: DATA_W];
    assign pre_sel  = 2'd3 - idx[1:0];
    assign busy     = (state != IDLE);

    always_comb begin
        state_d = state;
        idx_d   = idx;
        shift_d = shift;
        ser_d   = ser_out;
        fa_d    = frame_active;
        ack_d   = '0;
        gid_d   = gnt_id;
        advance = 1'b0;
        case (state)
            IDLE: begin
                // Grant edge ignores bit_en; the line stays idle until the next strobe.
                if (|win_onehot) begin
                    advance = 1'b1;
                    ack_d   = win_onehot;
                    gid_d   = win_id;
                    shift_d = {win_id, win_word};
                    idx_d   = '0;
                    state_d = PRE;
                end
            end
            PRE: begin
                if (bit_en) begin
                    ser_d = PREAMBLE[pre_sel];
                    fa_d  = 1'b1;
                    if (idx == CNT_W'(3)) begin
                        idx_d   = '0;
                        state_d = PAY;
                    end else begin
                        idx_d = idx + CNT_W'(1);
                    end
                end
            end
            PAY: begin
                if (bit_en) begin
                    ser_d   = shift[PAY_LEN-1];
                    shift_d = shift << 1;
                    if (idx == CNT_W'(PAY_LEN - 1)) begin
                        idx_d   = '0;
                        state_d = GAP;
                    end else begin
                        idx_d = idx + CNT_W'(1);
                    end
                end
            end
            GAP: begin
                if (bit_en) begin
                    ser_d = LINE_IDLE;
                    fa_d  = 1'b0;
                    if (idx == CNT_W'(GAP_BITS - 1)) begin
                        idx_d   = '0;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
                ser_d   = LINE_IDLE;
                fa_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            idx          <= '0;
            shift        <= '0;
            ser_out      <= LINE_IDLE;
            frame_active <= 1'b0;
            ack          <= '0;
            gnt_id       <= '0;
        end else begin
            state        <= state_d;
            idx          <= idx_d;
            shift        <= shift_d;
            ser_out      <= ser_d;
            frame_active <= fa_d;
            ack          <= ack_d;
            gnt_id       <= gid_d;
        end
    end

endmodule

// File: tb/tb_serial_frame_arbiter.sv
// Directed bench for serial_frame_arbiter with a line scoreboard and a simple preamble receiver model.
module tb_serial_frame_arbiter;

    localparam int NREQ     = 4;
    localparam int DATA_W   = 4;
    localparam int GAP_BITS = 2;
    localparam int ID_W     = 2;
    localparam int PAY_LEN  = ID_W + DATA_W;
    localparam int FRAME    = 4 + PAY_LEN + GAP_BITS;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   bit_en;
    logic [NREQ-1:0]        req;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        ack;
    logic                   ser_out;
    logic                   frame_active;
    logic                   busy;
    logic [ID_W-1:0]        gnt_id;

    serial_frame_arbiter #(
        .NREQ     (NREQ),
        .DATA_W   (DATA_W),
        .GAP_BITS (GAP_BITS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bit_en       (bit_en),
        .req          (req),
        .req_data     (req_data),
        .ack          (ack),
        .ser_out      (ser_out),
        .frame_active (frame_active),
        .busy         (busy),
        .gnt_id       (gnt_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic b;
        logic fa;
        logic bz;
    } exp_bit_t;

    exp_bit_t   exp_q[$];
    logic [7:0] frm_q[$];
    logic [7:0] rx_q[$];

    int tests = 0;
    int fails = 0;

    // Strobe generator: fixed period or random spacing.
    int period    = 3;
    bit mode_rand = 1'b0;
    int sc        = 0;

    initial begin
        bit_en = 1'b0;
        forever begin
            @(negedge clk);
            if (mode_rand) begin
                bit_en = ($urandom_range(0, 2) == 0);
            end else begin
                sc++;
                if (sc >= period) begin
                    sc     = 0;
                    bit_en = 1'b1;
                end else begin
                    bit_en = 1'b0;
                end
            end
        end
    end

    // Receiver model: waits for 1011, then takes PAY_LEN payload bits.
    bit         rx_on   = 1'b0;
    bit         rx_pay  = 1'b0;
    logic [3:0] rx_hist = 4'b0;
    logic [7:0] rx_sh   = 8'b0;
    int         rx_cnt  = 0;

    always @(posedge clk) begin
        if (rx_on && bit_en) begin
            #1;
            if (!rx_pay) begin
                rx_hist = {rx_hist[2:0], ser_out};
                if (rx_hist == 4'b1011) begin
                    rx_pay = 1'b1;
                    rx_cnt = 0;
                    rx_sh  = 8'b0;
                end
            end else begin
                rx_sh = {rx_sh[6:0], ser_out};
                rx_cnt++;
                if (rx_cnt == PAY_LEN) begin
                    rx_q.push_back(rx_sh);
                    rx_pay  = 1'b0;
                    rx_hist = 4'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_frame(input logic [ID_W-1:0] id, input logic [DATA_W-1:0] data);
        logic [3:0]         pre;
        logic [PAY_LEN-1:0] pay;
        exp_bit_t           e;
        pre = 4'b1011;
        pay = {id, data};
        for (int i = 3; i >= 0; i--) begin
            e.b = pre[i]; e.fa = 1'b1; e.bz = 1'b1;
            exp_q.push_back(e);
        end
        for (int i = PAY_LEN - 1; i >= 0; i--) begin
            e.b = pay[i]; e.fa = 1'b1; e.bz = 1'b1;
            exp_q.push_back(e);
        end
        for (int i = 0; i < GAP_BITS; i++) begin
            e.b = 1'b0; e.fa = 1'b0; e.bz = (i < GAP_BITS - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic collect(input int n);
        exp_bit_t e;
        int       guard;
        for (int i = 0; i < n; i++) begin
            guard = 0;
            do begin
                @(posedge clk);
                guard++;
            end while (!bit_en && guard < 50);
            #1;
            check("strobe_seen", {31'b0, bit_en}, 32'd1);
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("ser_out", {31'b0, ser_out}, {31'b0, e.b});
                check("frame_active", {31'b0, frame_active}, {31'b0, e.fa});
                check("busy", {31'b0, busy}, {31'b0, e.bz});
                check("ack_quiet", {28'b0, ack}, 32'd0);
            end
        end
    endtask

    task automatic wait_ack(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (ack == '0 && cycles < 300);
        check("ack_seen", {31'b0, |ack}, 32'd1);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while (busy && guard < 400) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("idle_reached", {31'b0, busy}, 32'd0);
    endtask

    int         cyc;
    logic [3:0] exp_ack;
    int         order[5] = '{0, 1, 2, 3, 0};
    logic [1:0] rid;
    logic [3:0] rdat;
    logic [7:0] got;
    logic [7:0] want;

    initial begin
        rst_n    = 1'b0;
        req      = '0;
        req_data = '0;
        repeat (3) @(negedge clk);
        check("rst_ser_out", {31'b0, ser_out}, 32'd0);
        check("rst_ack", {28'b0, ack}, 32'd0);
        check("rst_frame_active", {31'b0, frame_active}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_gnt_id", {30'b0, gnt_id}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_no_req_line", {31'b0, ser_out}, 32'd0);
        check("idle_no_req_busy", {31'b0, busy}, 32'd0);

        // All four requesting: fair rotation 0,1,2,3,0.
        for (int i = 0; i < NREQ; i++) req_data[i*DATA_W +: DATA_W] = 4'(5 + i);
        req = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            wait_ack(cyc);
            exp_ack = 4'b0001 << order[f];
            check("rr_ack", {28'b0, ack}, {28'b0, exp_ack});
            check("rr_gnt_id", {30'b0, gnt_id}, 32'(order[f]));
            if (f == 4) req = '0;
            push_frame(2'(order[f]), 4'(5 + order[f]));
            collect(FRAME);
        end

        // Single request from requester 2; data changes after ack must not leak.
        req_data[2*DATA_W +: DATA_W] = 4'hA;
        req = 4'b0100;
        wait_ack(cyc);
        check("single_ack", {28'b0, ack}, 32'h4);
        check("single_gnt_id", {30'b0, gnt_id}, 32'd2);
        req_data[2*DATA_W +: DATA_W] = 4'hF;
        @(posedge clk);
        #1;
        check("ack_one_cycle", {28'b0, ack}, 32'd0);
        push_frame(2'd2, 4'hA);
        // Requester 3 asks mid-frame but drops before IDLE; 0 and 1 then ask.
        req = 4'b1000;
        collect(6);
        req = 4'b0011;
        collect(FRAME - 6);

        // Pointer sits at 3; only 0 and 1 pending, so 0 wins after the wrap.
        req_data[0*DATA_W +: DATA_W] = 4'hC;
        req_data[1*DATA_W +: DATA_W] = 4'h6;
        wait_ack(cyc);
        check("wrap_ack0", {28'b0, ack}, 32'h1);
        check("wrap_gnt0", {30'b0, gnt_id}, 32'd0);
        req = 4'b0010;
        push_frame(2'd0, 4'hC);
        collect(FRAME);
        wait_ack(cyc);
        check("wrap_ack1", {28'b0, ack}, 32'h2);
        check("wrap_gnt1", {30'b0, gnt_id}, 32'd1);
        req = 4'b0000;
        push_frame(2'd1, 4'h6);
        collect(FRAME);

        // bit_en every clock: 12-clock frame, next grant right after GAP.
        wait_idle();
        period = 1;
        repeat (2) @(negedge clk);
        req_data[1*DATA_W +: DATA_W] = 4'h3;
        req_data[3*DATA_W +: DATA_W] = 4'h9;
        req = 4'b0010;
        wait_ack(cyc);
        check("fast_ack", {28'b0, ack}, 32'h2);
        req = 4'b1000;
        push_frame(2'd1, 4'h3);
        collect(FRAME);
        wait_ack(cyc);
        check("next_grant_latency", 32'(cyc), 32'd1);
        check("next_grant_ack", {28'b0, ack}, 32'h8);
        req = 4'b0000;
        push_frame(2'd3, 4'h9);
        collect(FRAME);

        // Reset in the middle of the payload.
        period = 3;
        req_data[0*DATA_W +: DATA_W] = 4'h8;
        req = 4'b0001;
        wait_ack(cyc);
        check("prerst_ack", {28'b0, ack}, 32'h1);
        req = 4'b0000;
        push_frame(2'd0, 4'h8);
        collect(7);
        check("prerst_line_high", {31'b0, ser_out}, 32'd1);
        exp_q.delete();
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_ser_out", {31'b0, ser_out}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_ack", {28'b0, ack}, 32'd0);
        check("midrst_frame_active", {31'b0, frame_active}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        req_data[1*DATA_W +: DATA_W] = 4'h5;
        req = 4'b0011;
        wait_ack(cyc);
        check("postrst_ack", {28'b0, ack}, 32'h1);
        check("postrst_gnt_id", {30'b0, gnt_id}, 32'd0);
        req = 4'b0000;
        push_frame(2'd0, 4'h8);
        collect(FRAME);

        // End to end through the receiver model with random strobe spacing.
        wait_idle();
        mode_rand = 1'b1;
        rx_q.delete();
        rx_on = 1'b1;
        for (int f = 0; f < 4; f++) begin
            rid  = 2'($urandom_range(0, 3));
            rdat = 4'($urandom_range(0, 15));
            req_data[rid*DATA_W +: DATA_W] = rdat;
            req = 4'b0001 << rid;
            wait_ack(cyc);
            check("e2e_gnt_id", {30'b0, gnt_id}, {30'b0, rid});
            req = 4'b0000;
            frm_q.push_back({2'b00, rid, rdat});
            wait_idle();
            check("e2e_rx_count", 32'(rx_q.size()), 32'd1);
            check("e2e_rx_idle", {31'b0, rx_pay}, 32'd0);
            if (rx_q.size() > 0 && frm_q.size() > 0) begin
                got  = rx_q.pop_front();
                want = frm_q.pop_front();
                check("e2e_payload", {24'b0, got}, {24'b0, want});
            end
            rx_q.delete();
            frm_q.delete();
        end
        rx_on = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
